// File: rtl/keccak_pkg.sv
// Shared Keccak/SHA-3 constants, squeeze FSM encoding and rate helpers used by
// the squeeze engine and sha3_setup.
package keccak_pkg;

  localparam int LANE_SIZE           = 64;
  localparam int NUM_LANES           = 25;
  localparam int STATE_WIDTH         = LANE_SIZE * NUM_LANES;
  localparam int MAX_RATE_LANES      = 21;
  localparam int RATE_LANE_IDX_WIDTH = 5;

  // Rate in bytes (r/8) for each supported function.
  localparam logic [7:0] RATE_SHA3_224 = 8'd144;
  localparam logic [7:0] RATE_SHA3_256 = 8'd136;
  localparam logic [7:0] RATE_SHA3_384 = 8'd104;
  localparam logic [7:0] RATE_SHA3_512 = 8'd72;
  localparam logic [7:0] RATE_SHAKE128 = 8'd168;
  localparam logic [7:0] RATE_SHAKE256 = 8'd136;

  typedef enum logic [1:0] {
    SQZ_IDLE,
    SQZ_WAIT_STATE,
    SQZ_STREAM
  } squeeze_state_t;

  // Out-of-range rates fall back to the widest legal rate so the lane counter
  // always wraps inside the state.
  function automatic logic [RATE_LANE_IDX_WIDTH-1:0] rate_lanes_of(input logic [7:0] rate_bytes);
    logic [RATE_LANE_IDX_WIDTH-1:0] lanes;
    lanes = rate_bytes[7:3];
    if (lanes == '0 || lanes > RATE_LANE_IDX_WIDTH'(MAX_RATE_LANES))
      lanes = RATE_LANE_IDX_WIDTH'(MAX_RATE_LANES);
    return lanes;
  endfunction

endpackage

// File: rtl/keccak_lane_select.sv
// Combinational beat formatter: picks the current rate lane out of the state
// and derives byte enables and the last flag from the remaining byte count.
module keccak_lane_select
  import keccak_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic [STATE_WIDTH-1:0]         state_array,
  input  logic [RATE_LANE_IDX_WIDTH-1:0] lane_idx,
  input  logic [LEN_WIDTH-1:0]           bytes_left,
  output logic [LANE_SIZE-1:0]           lane_data,
  output logic [7:0]                     keep,
  output logic                           last
);

  // NOTE: every output gets a default before any conditional assignment so no
  // latch is inferred.
  always_comb begin
    lane_data = '0;
    for (int i = 0; i < MAX_RATE_LANES; i++) begin
      if (lane_idx == RATE_LANE_IDX_WIDTH'(i))
        lane_data = state_array[i*LANE_SIZE +: LANE_SIZE];
    end
  end

  always_comb begin
    keep = 8'hFF;
    if (bytes_left < LEN_WIDTH'(8))
      keep = (8'd1 << bytes_left[2:0]) - 8'd1;
    last = (bytes_left <= LEN_WIDTH'(8));
  end

endmodule

// File: rtl/keccak_squeeze.sv
// Squeeze-phase output engine: streams rate lanes of the Keccak state as
// 64-bit AXI4-Stream beats, truncated to the job length, requesting further
// permutations when a rate block runs out.
module keccak_squeeze
  import keccak_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int KEEP_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [7:0]             rate_bytes_i,
  input  logic [LEN_WIDTH-1:0]   out_len_i,
  input  logic [STATE_WIDTH-1:0] state_array_i,
  input  logic                   state_valid_i,
  output logic                   perm_req_o,
  output logic                   done_o,
  output logic [DWIDTH-1:0]      t_data_o,
  output logic [KEEP_WIDTH-1:0]  t_keep_o,
  output logic                   t_valid_o,
  output logic                   t_last_o,
  input  logic                   t_ready_i
);

  squeeze_state_t                 state_q, state_d;
  logic [RATE_LANE_IDX_WIDTH-1:0] rate_lanes_q;
  logic [RATE_LANE_IDX_WIDTH-1:0] lane_idx_q;
  logic [LEN_WIDTH-1:0]           bytes_left_q;
  logic                           perm_req_q;
  logic                           done_q;

  logic [LANE_SIZE-1:0] sel_data;
  logic [7:0]           sel_keep;
  logic                 sel_last;
  logic                 streaming;
  logic                 handshake;
  logic                 lane_wrap;

  keccak_lane_select #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_lane_select (
    .state_array (state_array_i),
    .lane_idx    (lane_idx_q),
    .bytes_left  (bytes_left_q),
    .lane_data   (sel_data),
    .keep        (sel_keep),
    .last        (sel_last)
  );

  assign streaming = (state_q == SQZ_STREAM);
  assign handshake = streaming && t_ready_i;
  assign lane_wrap = (lane_idx_q == rate_lanes_q - RATE_LANE_IDX_WIDTH'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SQZ_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SQZ_IDLE:
        if (start_i && out_len_i != '0) state_d = SQZ_WAIT_STATE;
      SQZ_WAIT_STATE:
        // A valid pulse coincident with our own request describes the old state.
        if (state_valid_i && !perm_req_q) state_d = SQZ_STREAM;
      SQZ_STREAM:
        if (handshake) begin
          if (sel_last)       state_d = SQZ_IDLE;
          else if (lane_wrap) state_d = SQZ_WAIT_STATE;
        end
      default: state_d = SQZ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_lanes_q <= RATE_LANE_IDX_WIDTH'(MAX_RATE_LANES);
      lane_idx_q   <= '0;
      bytes_left_q <= '0;
      perm_req_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      perm_req_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        SQZ_IDLE:
          if (start_i) begin
            rate_lanes_q <= rate_lanes_of(rate_bytes_i);
            bytes_left_q <= out_len_i;
            lane_idx_q   <= '0;
            if (out_len_i == '0) done_q <= 1'b1;
          end
        SQZ_STREAM:
          if (handshake) begin
            // The last beat carries at most 8 bytes, so clearing is min(8, left).
            bytes_left_q <= sel_last ? '0 : bytes_left_q - LEN_WIDTH'(8);
            if (sel_last) begin
              done_q <= 1'b1;
            end else if (lane_wrap) begin
              lane_idx_q <= '0;
              perm_req_q <= 1'b1;
            end else begin
              lane_idx_q <= lane_idx_q + RATE_LANE_IDX_WIDTH'(1);
            end
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    t_valid_o  = streaming;
    t_data_o   = streaming ? DWIDTH'(sel_data) : '0;
    t_keep_o   = streaming ? KEEP_WIDTH'(sel_keep) : '0;
    t_last_o   = streaming && sel_last;
    perm_req_o = perm_req_q;
    done_o     = done_q;
  end

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze: a small core model answers perm_req_o
// with fresh states, and every beat is compared with the expected lane bytes.
module tb_keccak_squeeze;
  import keccak_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start_i;
  logic [7:0]             rate_bytes_i;
  logic [15:0]            out_len_i;
  logic [STATE_WIDTH-1:0] state_array_i;
  logic                   state_valid_i;
  logic                   perm_req_o;
  logic                   done_o;
  logic [63:0]            t_data_o;
  logic [7:0]             t_keep_o;
  logic                   t_valid_o;
  logic                   t_last_o;
  logic                   t_ready_i;

  int n_tests = 0;
  int n_fail  = 0;

  keccak_squeeze #(
    .DWIDTH     (64),
    .KEEP_WIDTH (8),
    .LEN_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .rate_bytes_i  (rate_bytes_i),
    .out_len_i     (out_len_i),
    .state_array_i (state_array_i),
    .state_valid_i (state_valid_i),
    .perm_req_o    (perm_req_o),
    .done_o        (done_o),
    .t_data_o      (t_data_o),
    .t_keep_o      (t_keep_o),
    .t_valid_o     (t_valid_o),
    .t_last_o      (t_last_o),
    .t_ready_i     (t_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every byte of a lane is distinct per (seed, lane) so misordering shows up.
  function automatic logic [63:0] lane_val(input logic [7:0] seed, input int i);
    logic [7:0] idx;
    idx = 8'(i);
    return {seed, idx, 16'hC0DE, ~seed, idx ^ 8'h5A, 16'h1234};
  endfunction

  function automatic logic [STATE_WIDTH-1:0] mk_state(input logic [7:0] seed);
    logic [STATE_WIDTH-1:0] s;
    for (int i = 0; i < NUM_LANES; i++) s[i*64 +: 64] = lane_val(seed, i);
    return s;
  endfunction

  // Runs one job: start, core answers each perm_req_o four cycles later,
  // optional stale state_valid_i in the perm_req_o cycle, optional backpressure.
  task automatic run_job(input logic [7:0] rate, input logic [15:0] len, input logic [7:0] seed,
                         input bit rand_rdy, input bit stale,
                         output int beats, output int perms,
                         output logic [7:0] last_keep, output logic [63:0] last_data);
    int         lanes, nbeats, countdown, cyc, last_cyc, sv_cyc, stale_cyc, j, rem, blk;
    bit         await_first, stalled, done_seen;
    logic [7:0] cur_seed, ekeep;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    lanes = int'(rate[7:3]);
    if (lanes == 0 || lanes > 21) lanes = 21;
    nbeats = (int'(len) + 7) / 8;
    countdown = 1; cyc = 0; last_cyc = -10; sv_cyc = -10; stale_cyc = -10;
    await_first = 0; stalled = 0; done_seen = 0;
    cur_seed = seed; beats = 0; perms = 0; last_keep = '0; last_data = '0;
    sd = '0; sk = '0; sl = 1'b0;

    @(posedge clk); #1;
    start_i = 1'b1; rate_bytes_i = rate; out_len_i = len; t_ready_i = 1'b0;
    while (!done_seen && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start_i = 1'b0;
      state_valid_i = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          state_array_i = mk_state(cur_seed);
          state_valid_i = 1'b1;
          sv_cyc = cyc;
          await_first = 1;
        end
      end
      t_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (stale_cyc == cyc - 1) check("stale_valid_ignored", 64'(t_valid_o), 64'(0));
      if (stalled) begin
        check("stall_valid", 64'(t_valid_o), 64'(1));
        check("stall_data", t_data_o, sd);
        check("stall_keep", 64'(t_keep_o), 64'(sk));
        check("stall_last", 64'(t_last_o), 64'(sl));
        stalled = 0;
      end
      if (t_valid_o) begin
        if (await_first) begin
          check("first_beat_latency", 64'(cyc), 64'(sv_cyc + 1));
          await_first = 0;
        end
        if (t_ready_i) begin
          j = beats;
          blk = j / lanes;
          rem = int'(len) - 8 * j;
          ekeep = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
          check("beat_data", t_data_o, lane_val(seed + 8'(blk), j % lanes));
          check("beat_keep", 64'(t_keep_o), 64'(ekeep));
          check("beat_last", 64'(t_last_o), 64'(rem <= 8));
          last_keep = t_keep_o;
          last_data = t_data_o;
          beats++;
          last_cyc = cyc;
        end else begin
          stalled = 1;
          sd = t_data_o; sk = t_keep_o; sl = t_last_o;
        end
      end
      if (perm_req_o || done_o) check("perm_done_exclusive", 64'(perm_req_o & done_o), 64'(0));
      if (perm_req_o) begin
        perms++;
        check("perm_after_final_lane", 64'(last_cyc), 64'(cyc - 1));
        check("perm_block_boundary", 64'(beats % lanes), 64'(0));
        cur_seed = cur_seed + 8'd1;
        countdown = 4;
        if (stale) begin
          state_array_i = mk_state(8'hEE);
          state_valid_i = 1'b1;
          stale_cyc = cyc;
        end
      end
      if (done_o) begin
        done_seen = 1;
        check("done_timing", 64'(cyc), 64'((nbeats == 0) ? 1 : last_cyc + 1));
      end
    end
    if (!done_seen) check("done_timeout", 64'(0), 64'(1));
    state_valid_i = 1'b0;
    @(posedge clk); #2;
    check("done_single_cycle", 64'(done_o), 64'(0));
    check("idle_no_perm", 64'(perm_req_o), 64'(0));
    check("idle_no_valid", 64'(t_valid_o), 64'(0));
    check("beat_count", 64'(beats), 64'(nbeats));
    check("perm_count", 64'(perms), 64'((nbeats == 0) ? 0 : (nbeats - 1) / lanes));
  endtask

  initial begin
    int          beats, perms;
    logic [7:0]  lk;
    logic [63:0] ld;
    logic [STATE_WIDTH-1:0] ref_state;
    logic [31:0] ref_word;

    rst = 1'b1; start_i = 1'b0; rate_bytes_i = '0; out_len_i = '0;
    state_array_i = '0; state_valid_i = 1'b0; t_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_valid", 64'(t_valid_o), 64'(0));
    check("reset_last", 64'(t_last_o), 64'(0));
    check("reset_keep", 64'(t_keep_o), 64'(0));
    check("reset_data", t_data_o, 64'(0));
    check("reset_perm", 64'(perm_req_o), 64'(0));
    check("reset_done", 64'(done_o), 64'(0));
    rst = 1'b0;

    // SHA3-256
    run_job(RATE_SHA3_256, 16'd32, 8'h10, 0, 0, beats, perms, lk, ld);
    check("sha3_256_last_keep", 64'(lk), 64'hFF);

    // SHA3-224: last beat is half a lane
    run_job(RATE_SHA3_224, 16'd28, 8'h20, 0, 0, beats, perms, lk, ld);
    check("sha3_224_last_keep", 64'(lk), 64'h0F);
    ref_state = mk_state(8'h20);
    ref_word = ref_state[223:192];
    check("sha3_224_tail_word", 64'(ld[31:0]), 64'(ref_word));

    // SHAKE128 across a block boundary with a stale valid pulse
    run_job(RATE_SHAKE128, 16'd200, 8'h30, 0, 1, beats, perms, lk, ld);
    check("shake128_last_keep", 64'(lk), 64'hFF);
    check("shake128_beats", 64'(beats), 64'(25));

    // SHAKE256 with random backpressure
    run_job(RATE_SHAKE256, 16'd300, 8'h40, 1, 0, beats, perms, lk, ld);
    check("shake256_beats", 64'(beats), 64'(38));
    check("shake256_last_keep", 64'(lk), 64'h0F);

    // Length boundaries
    run_job(RATE_SHA3_256, 16'd0, 8'h50, 0, 0, beats, perms, lk, ld);
    run_job(RATE_SHA3_256, 16'd1, 8'h58, 0, 0, beats, perms, lk, ld);
    check("len1_keep", 64'(lk), 64'h01);

    // Illegal rate 0 falls back to 21 lanes
    run_job(8'd0, 16'd176, 8'h60, 0, 0, beats, perms, lk, ld);

    // Reset in the middle of a job
    @(posedge clk); #1;
    start_i = 1'b1; rate_bytes_i = RATE_SHA3_256; out_len_i = 16'd64; t_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; state_array_i = mk_state(8'h70); state_valid_i = 1'b1;
    @(posedge clk); #1;
    state_valid_i = 1'b0;
    #1;
    check("rst_job_beat1", t_data_o, lane_val(8'h70, 0));
    @(posedge clk); #2;
    check("rst_job_beat2", t_data_o, lane_val(8'h70, 1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #2;
    check("midrst_valid", 64'(t_valid_o), 64'(0));
    check("midrst_last", 64'(t_last_o), 64'(0));
    check("midrst_keep", 64'(t_keep_o), 64'(0));
    check("midrst_data", t_data_o, 64'(0));
    check("midrst_perm", 64'(perm_req_o), 64'(0));
    check("midrst_done", 64'(done_o), 64'(0));
    #1 rst = 1'b0;
    run_job(RATE_SHA3_256, 16'd24, 8'h80, 0, 0, beats, perms, lk, ld);
    check("post_rst_beats", 64'(beats), 64'(3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
